// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the execute stage and the
// iterative multiply/divide sequencer. The execute stage is the master; the
// sequencer is the slave.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over XLEN
// cycles, followed by one sign-correction cycle (ADJ) and a one-cycle done pulse.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- when defined, an operation whose
// op_a or op_b is zero skips the iterative phase and goes straight to ADJ.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ADJ,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        funct3_q;
  logic              sign_a_q;
  logic              sign_b_q;
  logic              b_zero_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode: which operands are signed, and their magnitudes.
  logic            a_signed, b_signed;
  logic            in_sign_a, in_sign_b;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  logic            in_zero;

  always_comb begin
    a_signed  = !(bus.funct3 == F_MULHU || bus.funct3 == F_DIVU || bus.funct3 == 3'b111);
    b_signed  = (bus.funct3 == F_MUL) || (bus.funct3 == F_MULH) ||
                (bus.funct3 == F_DIV) || (bus.funct3 == F_REM);
    in_sign_a = a_signed && bus.op_a[XLEN-1];
    in_sign_b = b_signed && bus.op_b[XLEN-1];
    in_mag_a  = in_sign_a ? -bus.op_a : bus.op_a;
    in_mag_b  = in_sign_b ? -bus.op_b : bus.op_b;
    in_zero   = (bus.op_a == '0) || (bus.op_b == '0);
  end

  // One iteration of shift-add multiply and of restoring divide.
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    prod_d = prod_q;
    rem_d  = rem_q;
    quo_d  = quo_q;

    // Multiply: high half accumulates the multiplicand when the current
    // multiplier bit (prod_q[0]) is set, then the whole register shifts right.
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
    prod_d  = {mul_sum, prod_q[XLEN-1:1]};

    // Divide: shift the next dividend bit into the partial remainder and keep
    // the trial difference only if it did not borrow.
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    if (!div_diff[XLEN]) begin
      rem_d = div_diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d = div_shift[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and special cases applied in ADJ.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  always_comb begin
    result_d = result_q;
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -quo_q  : quo_q;
    rem_fix  = sign_a_q ? -rem_q : rem_q;
    // Signed overflow (most negative / -1) needs no special path: the magnitude
    // quotient 2^(XLEN-1) negates back to itself and the remainder is zero.
    case (funct3_q)
      F_MUL:                      result_d = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  result_d = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              result_d = b_zero_q ? '1 : quo_fix;
      // REM / REMU: dividing by zero returns op_a as it was presented.
      default:                    result_d = b_zero_q ? (sign_a_q ? -mag_a_q : mag_a_q)
                                                      : rem_fix;
    endcase
  end

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    // NOTE: every register, including the wide datapath registers, is cleared so a reset mid-operation leaves nothing stale.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            funct3_q <= bus.funct3;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            b_zero_q <= (bus.op_b == '0);
            mag_a_q  <= in_mag_a;
            mag_b_q  <= in_mag_b;
            busy_q   <= 1'b1;
            cnt_q    <= CW'(XLEN - 1);
            if (EARLY_OUT && in_zero) begin
              // Zero product, zero quotient/remainder; divide-by-zero is
              // resolved from b_zero_q in ADJ.
              prod_q  <= '0;
              rem_q   <= '0;
              quo_q   <= '0;
              state_q <= S_ADJ;
            end else begin
              prod_q  <= {{XLEN{1'b0}}, in_mag_b};
              rem_q   <= '0;
              quo_q   <= in_mag_a;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (funct3_q[2]) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
          end else begin
            prod_q <= prod_d;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= S_ADJ;
          end
        end
        S_ADJ: begin
          result_q <= result_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for muldiv_seq with a scoreboard.
// The driver pushes the hand-computed result, start cycle and latency of each
// accepted request; an independent monitor pops an entry on every done pulse.
// Optional feature macro: MULDIV_EARLY_OUT_EN (changes expected latency only).
module tb_muldiv_seq;

  localparam int XLEN = 32;
  localparam int FULL_LAT = XLEN + 2;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] res;
    int          start_cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_for(input logic [31:0] a, input logic [31:0] b);
    if (EARLY && (a == 32'd0 || b == 32'd0)) return 2;
    return FULL_LAT;
  endfunction

  // Monitor: compare every done pulse against the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, bus.result, e.res);
          check({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
          check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat - 1));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic issue(input string name, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res);
    exp_t e;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    e.name      = name;
    e.res       = res;
    e.start_cyc = cyc;
    e.lat       = lat_for(a, b);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b111;
    bus.op_a   = 32'hDEAD_BEEF;
    bus.op_b   = 32'hDEAD_BEEF;
    wait_idle();
  endtask

  initial begin
    exp_t e;
    int   c;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);

    // Multiply forms
    issue("mul_7_m3",      3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    issue("mulhu_max_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue("mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("mul_0_5",       3'b000, 32'd0,         32'd5,         32'd0);

    // Divide forms
    issue("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    issue("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    issue("divu_big_2",    3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);
    issue("remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2);

    // Signed overflow and divide by zero
    issue("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    issue("divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
    issue("rem_m5_0",      3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB);
    issue("div_m5_0",      3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF);
    issue("div_0_3",       3'b100, 32'd0,         32'd3,         32'd0);

    // start held high across an operation: inputs change mid-op and are only
    // taken again in the IDLE cycle after done.
    @(posedge clk); #1;
    c = cyc;
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd5;
    bus.op_b   = 32'd6;
    e.name = "held_mul_5_6"; e.res = 32'd30; e.start_cyc = c; e.lat = FULL_LAT;
    sb.push_back(e);
    repeat (5) @(posedge clk); #1;
    bus.funct3 = 3'b101;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    repeat (FULL_LAT - 4) @(posedge clk); #1;
    e.name = "held_divu_100_7"; e.res = 32'd14; e.start_cyc = c + FULL_LAT + 1; e.lat = FULL_LAT;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();

    // Reset in the middle of a divide: no done may follow.
    @(posedge clk); #1;
    c = cyc;
    bus.start  = 1'b1;
    bus.funct3 = 3'b100;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < c + 10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_done", {31'd0, bus.done}, 32'd0);
    check("midreset_result", bus.result, 32'd0);
    repeat (50) @(posedge clk);
    issue("post_reset_mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the integer ALU in the execute stage.
- Accepts one operation per start pulse and runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
- Raises busy so the hazard unit can freeze the pipeline, then pulses done with the result.
- Operation select uses the instruction funct3 field, the same field the ALU decode consumes.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 operand (multiplicand/dividend).
- op_b  input  XLEN  rs2 operand (multiplier/divisor).
- busy  output  1  registered; high while an operation is in flight.
- done  output  1  registered; one-cycle pulse when result is valid.
- result  output  XLEN  registered; held from done until the next done.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, internal accumulators/counter=0. Reset mid-operation aborts the operation; no done is produced.
- States and transitions:
  - IDLE -> CALC on start=1. funct3, operand signs and operand magnitudes are latched. Signed forms take two's-complement magnitude; MULHSU treats only op_a as signed.
  - CALC runs exactly XLEN cycles (counter XLEN-1 down to 0), one bit per cycle.
    - Multiply: 2*XLEN-bit product register.
    - Divide: remainder/quotient shift register, one trial subtract per cycle.
  - CALC -> ADJ when the counter reaches 0.
  - ADJ (1 cycle): sign correction and special cases, written into result.
  - ADJ -> DONE.
  - DONE: done=1 for this cycle, then -> IDLE.
- Latency: start sampled high at edge t -> busy=1 from t+1 through t+XLEN+1 -> done=1 at t+XLEN+2. Next start is accepted in the cycle after DONE.
- start while not IDLE: ignored. Inputs are don't-care outside the start cycle.
- The hazard unit combines start with busy for the first stall cycle; busy itself stays purely registered.
- Result selection:
  - MUL returns the low XLEN bits of the product.
  - MULH/MULHSU/MULHU return the high XLEN bits.
  - Product negated when signs differ (MULH: a^b; MULHSU: a only).
- Quotient sign = sign_a ^ sign_b. Remainder sign = sign_a. Negation is applied in ADJ.
- Divide by zero (op_b=0):
  - DIV/DIVU quotient = all ones.
  - REM/REMU = op_a unchanged, no sign fix applied.
- Signed overflow (DIV, op_a=-2^(XLEN-1), op_b=-1): quotient = -2^(XLEN-1), remainder = 0.
- All arithmetic is modulo 2^XLEN on result; no exceptions or flags.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- With the macro defined: if op_b==0, or op_a==0 for any op, IDLE -> ADJ directly, skipping CALC. done then arrives at t+2, busy is high at t+1 only, and results equal the full-latency values.
- Without the macro: every operation takes the full XLEN+2 latency.

Test Plan:
- MUL, op_a=7, op_b=-3 (0xFFFFFFFD), start at cycle 0 -> done at cycle 34, result=0xFFFFFFEB; busy high cycles 1-33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC. REMU 100/7 -> 2.
- DIV 0x80000000/-1 -> 0x80000000, REM -> 0. DIVU 5/0 -> 0xFFFFFFFF, REM -5/0 -> 0xFFFFFFFB. Same ops with MULDIV_EARLY_OUT_EN: done at cycle 2, identical results.
- start re-asserted every cycle during an op -> exactly one done per accepted start; the second op is accepted in the cycle after done.
- rst=1 at cycle 10 of a DIV -> cycle 11 busy=0, done=0, result=0; no done afterwards; a fresh MUL 3x4 then gives 12 at full latency.
